ex_mult_hilo: RTL and testbench
===============================

Name: ex_mult_hilo

Overview:
- Iterative multiply unit with architectural HI/LO registers, sitting in the EX stage beside EX_ALU.
- Consumes the ID_EX operands (Read_Data_1_EX, Read_Data_2_EX) for MULT/MULTU/MTHI/MTLO.
- Supplies HI/LO to the EX result path for MFHI/MFLO.
- Busy_EX drives the ID-stage stall so that no MFHI/MFLO/MULT issues while a product is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start_EX  input  1  request a multiply; accepted only in IDLE.
- Signed_EX  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with Start_EX.
- Read_Data_1_EX  input  WIDTH  multiplicand (rs); also MTHI/MTLO source data.
- Read_Data_2_EX  input  WIDTH  multiplier (rt).
- MTHI_EX  input  1  write Read_Data_1_EX into HI.
- MTLO_EX  input  1  write Read_Data_1_EX into LO.
- HI_EX  output  WIDTH  current HI register.
- LO_EX  output  WIDTH  current LO register.
- Busy_EX  output  1  multiply in progress; stall request to ID.
- Done_EX  output  1  one-cycle pulse in the cycle HI/LO first show the new product.

Behaviour:
- Reset values (Reset high at an edge): state=IDLE, HI_EX=0, LO_EX=0, Busy_EX=0, Done_EX=0, counter=0, internal accumulator/operands=0. Reset overrides every other input.
- States: IDLE, RUN, FINISH.
- IDLE, Start_EX=1 at edge E0:
  - latch |Read_Data_1_EX| and |Read_Data_2_EX| (magnitudes only when Signed_EX=1; raw values otherwise);
  - latch neg = Signed_EX & (msb1 ^ msb2);
  - clear the 2*WIDTH accumulator and counter;
  - go to RUN.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned; no overflow case exists.
- RUN: each edge performs one radix-2 shift-add step: if multiplier lsb is 1, accumulator += multiplicand << counter; multiplier >>= 1; counter++. When counter reaches WIDTH-1 at the step, go to FINISH. This gives WIDTH steps at edges E1..E32.
- FINISH (edge E33): {HI,LO} = neg ? -acc : acc, computed as 2*WIDTH-bit two's complement. State returns to IDLE.
- Done_EX: registered, high for exactly the cycle following E33.
- Busy_EX: registered, 1 from after E0 through E33; falls together with the rise of Done_EX. Latency: 33 edges from accept to result visible.
- Start_EX while Busy_EX=1: ignored (ID guarantees it is stalled); no queueing.
- MTHI_EX/MTLO_EX in IDLE: written at the edge.
- MTHI_EX/MTLO_EX while Busy_EX=1: dropped; the HI/LO pair produced by FINISH is authoritative.
- Start_EX and MTHI/MTLO in the same IDLE cycle: the move is written now; the product overwrites it at FINISH.
- MTHI_EX and MTLO_EX together: both written with Read_Data_1_EX.
- HI_EX/LO_EX are direct register outputs, with no combinational path from inputs. They hold their old value throughout RUN and change only at FINISH, on a move, or on reset.
- Reset mid-RUN: abort at once. The next cycle shows IDLE, HI=LO=0, Busy=0, and no Done pulse.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, FINISH=2'd2);
  - the default WIDTH;
  - MULT/MULTU funct codes (6'h18, 6'h19) and MFHI/MTHI/MFLO/MTLO funct codes (6'h10/6'h11/6'h12/6'h13), for the ID control decoder.
- One sub-module, ex_mult_shift_add: the accumulator/operand/counter datapath with a step and load interface. ex_mult_hilo keeps the FSM, sign handling and HI/LO registers.

Test Plan:
- Unsigned 7 x 6 (Signed=0), Start for 1 cycle → Busy high 33 cycles; Done pulses once; HI=0x00000000, LO=0x0000002A.
- Signed 0xFFFFFFFD x 5 (-3x5) → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Boundary operands:
  - MULTU 0xFFFFFFFF x 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001;
  - MULT 0x80000000 x 0x80000000 → HI=0x40000000, LO=0x00000000.
- Moves:
  - MTHI 0x12345678 in IDLE → HI_EX=0x12345678 next cycle, LO unchanged;
  - MTLO during RUN → dropped; final LO equals the product.
- Start held high through RUN with new operands → no second multiply; result matches the first operands only; exactly one Done pulse.
- Reset asserted 10 cycles into RUN after a prior HI=0x0000ABCD → next cycle HI=LO=0, Busy=0, and Done never pulses for the aborted operation.

Source files
------------

// File: rtl/ex_mult_hilo_pkg.sv
// Shared definitions for the EX-stage multiply unit and the ID control decoder.
//   - mult_state_t : FSM state encoding of ex_mult_hilo
//   - DEFAULT_WIDTH: default operand width (HI and LO are each this wide)
//   - FUNCT_*      : R-type funct codes for MULT/MULTU and the HI/LO moves
package ex_mult_hilo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/ex_mult_shift_add.sv
// Radix-2 shift-add datapath: unsigned multiplicand/multiplier registers,
// a 2*WIDTH accumulator and an iteration counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture mcand_in/mplier_in, clear accumulator and counter
//   step       : one iteration (add shifted multiplicand if multiplier lsb set)
//   acc        : running unsigned product
//   last       : the current step is the final one (counter == WIDTH-1)
module ex_mult_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      // The multiplicand stays put; its weight comes from the counter.
      if (mplier[0]) begin
        acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
      end
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mult_hilo.sv
// EX-stage iterative multiplier with architectural HI/LO registers.
//   Clk, Reset      : clock and synchronous active-high reset
//   Start_EX        : MULT/MULTU request, accepted only in IDLE
//   Signed_EX       : 1 = MULT (two's complement), 0 = MULTU
//   Read_Data_1_EX  : multiplicand; also MTHI/MTLO source
//   Read_Data_2_EX  : multiplier
//   MTHI_EX/MTLO_EX : move Read_Data_1_EX into HI/LO (IDLE only)
//   HI_EX/LO_EX     : HI/LO register outputs
//   Busy_EX         : product in flight, stalls ID
//   Done_EX         : one-cycle pulse when HI/LO first show the product
// Accept edge E0, WIDTH RUN steps, FINISH writes HI/LO: result visible after 33 edges.
module ex_mult_hilo
  import ex_mult_hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6             // 2**CNT_W must exceed WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start_EX,
  input  logic             Signed_EX,
  input  logic [WIDTH-1:0] Read_Data_1_EX,
  input  logic [WIDTH-1:0] Read_Data_2_EX,
  input  logic             MTHI_EX,
  input  logic             MTLO_EX,
  output logic [WIDTH-1:0] HI_EX,
  output logic [WIDTH-1:0] LO_EX,
  output logic             Busy_EX,
  output logic             Done_EX
);

  mult_state_t        state, next_state;
  logic               load, step, last;
  logic               neg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;

  // Two's complement magnitude; the most negative value maps to itself and
  // is then read as unsigned, so it needs no special case.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  ex_mult_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift_add (
    .clk       (Clk),
    .reset     (Reset),
    .load      (load),
    .step      (step),
    .mcand_in  (magnitude(Read_Data_1_EX, Signed_EX)),
    .mplier_in (magnitude(Read_Data_2_EX, Signed_EX)),
    .acc       (acc),
    .last      (last)
  );

  assign product = neg ? -acc : acc;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (Start_EX) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      HI_EX   <= '0;
      LO_EX   <= '0;
      Busy_EX <= 1'b0;
      Done_EX <= 1'b0;
      neg     <= 1'b0;
    end else begin
      state   <= next_state;
      Done_EX <= 1'b0;
      case (state)
        IDLE: begin
          // A move in the same cycle as Start is kept until FINISH overwrites it.
          if (MTHI_EX) HI_EX <= Read_Data_1_EX;
          if (MTLO_EX) LO_EX <= Read_Data_1_EX;
          if (Start_EX) begin
            Busy_EX <= 1'b1;
            neg     <= Signed_EX & (Read_Data_1_EX[WIDTH-1] ^ Read_Data_2_EX[WIDTH-1]);
          end
        end
        FINISH: begin
          {HI_EX, LO_EX} <= product;
          Busy_EX        <= 1'b0;
          Done_EX        <= 1'b1;
        end
        default: ;  // RUN: moves and new starts are dropped
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mult_hilo.sv
// Self-checking bench for ex_mult_hilo: directed cases plus random multiplies
// checked against a plain 64-bit arithmetic reference.
module tb_ex_mult_hilo;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start_EX;
  logic        Signed_EX;
  logic [31:0] Read_Data_1_EX;
  logic [31:0] Read_Data_2_EX;
  logic        MTHI_EX;
  logic        MTLO_EX;
  logic [31:0] HI_EX;
  logic [31:0] LO_EX;
  logic        Busy_EX;
  logic        Done_EX;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  ex_mult_hilo dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Start_EX       (Start_EX),
    .Signed_EX      (Signed_EX),
    .Read_Data_1_EX (Read_Data_1_EX),
    .Read_Data_2_EX (Read_Data_2_EX),
    .MTHI_EX        (MTHI_EX),
    .MTLO_EX        (MTLO_EX),
    .HI_EX          (HI_EX),
    .LO_EX          (LO_EX),
    .Busy_EX        (Busy_EX),
    .Done_EX        (Done_EX)
  );

  // Reference: full 64-bit product by ordinary arithmetic.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  // Run one multiply; inputs change only just after falling edges, outputs are
  // sampled on falling edges.
  task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] exp;
    logic [31:0] hold_hi, hold_lo;
    logic        held_ok, done_early;
    int          cyc;
    exp = ref_product(a, b, s);
    @(negedge Clk);
    Start_EX = 1'b1; Signed_EX = s; Read_Data_1_EX = a; Read_Data_2_EX = b;
    @(negedge Clk);
    Start_EX = 1'b0; Signed_EX = 1'($urandom);
    Read_Data_1_EX = $urandom; Read_Data_2_EX = $urandom;
    hold_hi = HI_EX; hold_lo = LO_EX; held_ok = 1'b1; done_early = 1'b0; cyc = 0;
    while (Busy_EX === 1'b1 && cyc < 50) begin
      cyc++;
      if (HI_EX !== hold_hi || LO_EX !== hold_lo) held_ok = 1'b0;
      if (Done_EX !== 1'b0) done_early = 1'b1;
      @(negedge Clk);
    end
    n_checks++;
    if (cyc !== 33) begin
      n_fail++; $display("FAIL busy_len a=%h b=%h s=%0d: got %0d cycles, want 33", a, b, s, cyc);
    end
    n_checks++;
    if (held_ok !== 1'b1 || done_early !== 1'b0) begin
      n_fail++; $display("FAIL run_hold a=%h b=%h: hilo_changed=%0d early_done=%0d, want 0 0",
                         a, b, !held_ok, done_early);
    end
    n_checks++;
    if (Done_EX !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse a=%h b=%h: got %b, want 1", a, b, Done_EX);
    end
    n_checks++;
    if ({HI_EX, LO_EX} !== exp) begin
      n_fail++; $display("FAIL product a=%h b=%h s=%0d: got %h_%h, want %h", a, b, s,
                         HI_EX, LO_EX, exp);
    end
    @(negedge Clk);
    n_checks++;
    if (Done_EX !== 1'b0) begin
      n_fail++; $display("FAIL done_width a=%h b=%h: got %b, want 0", a, b, Done_EX);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start_EX = 1'b0; Signed_EX = 1'b0; MTHI_EX = 1'b0; MTLO_EX = 1'b0;
    Read_Data_1_EX = 32'h0; Read_Data_2_EX = 32'h0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (HI_EX !== 32'h0 || LO_EX !== 32'h0 || Busy_EX !== 1'b0 || Done_EX !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0",
                         HI_EX, LO_EX, Busy_EX, Done_EX);
    end
  endtask

  task automatic test_plan_vectors;
    test_mult(32'd7, 32'd6, 1'b0);
    n_checks++;
    if (HI_EX !== 32'h0 || LO_EX !== 32'h2A) begin
      n_fail++; $display("FAIL u7x6: got %h_%h, want 00000000_0000002a", HI_EX, LO_EX);
    end
    test_mult(32'hFFFFFFFD, 32'd5, 1'b1);
    n_checks++;
    if (HI_EX !== 32'hFFFFFFFF || LO_EX !== 32'hFFFFFFF1) begin
      n_fail++; $display("FAIL s_m3x5: got %h_%h, want ffffffff_fffffff1", HI_EX, LO_EX);
    end
    test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    n_checks++;
    if (HI_EX !== 32'hFFFFFFFE || LO_EX !== 32'h00000001) begin
      n_fail++; $display("FAIL u_max_sq: got %h_%h, want fffffffe_00000001", HI_EX, LO_EX);
    end
    test_mult(32'h80000000, 32'h80000000, 1'b1);
    n_checks++;
    if (HI_EX !== 32'h40000000 || LO_EX !== 32'h00000000) begin
      n_fail++; $display("FAIL s_min_sq: got %h_%h, want 40000000_00000000", HI_EX, LO_EX);
    end
  endtask

  task automatic test_moves_idle;
    logic [31:0] lo_before, hi_before;
    lo_before = LO_EX;
    @(negedge Clk);
    MTHI_EX = 1'b1; Read_Data_1_EX = 32'h12345678;
    @(negedge Clk);
    MTHI_EX = 1'b0;
    n_checks++;
    if (HI_EX !== 32'h12345678 || LO_EX !== lo_before) begin
      n_fail++; $display("FAIL mthi_idle: got %h_%h, want 12345678_%h", HI_EX, LO_EX, lo_before);
    end
    hi_before = HI_EX;
    MTLO_EX = 1'b1; Read_Data_1_EX = 32'hCAFEF00D;
    @(negedge Clk);
    MTLO_EX = 1'b0;
    n_checks++;
    if (HI_EX !== hi_before || LO_EX !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL mtlo_idle: got %h_%h, want %h_cafef00d", HI_EX, LO_EX, hi_before);
    end
    MTHI_EX = 1'b1; MTLO_EX = 1'b1; Read_Data_1_EX = 32'h0BADC0DE;
    @(negedge Clk);
    MTHI_EX = 1'b0; MTLO_EX = 1'b0;
    n_checks++;
    if (HI_EX !== 32'h0BADC0DE || LO_EX !== 32'h0BADC0DE) begin
      n_fail++; $display("FAIL mthi_mtlo_both: got %h_%h, want 0badc0de_0badc0de", HI_EX, LO_EX);
    end
  endtask

  // Moves alongside Start land immediately; moves during RUN are dropped.
  task automatic test_moves_busy;
    logic [63:0] exp;
    int          cyc;
    exp = ref_product(32'h0001F00D, 32'h00C0FFEE, 1'b0);
    @(negedge Clk);
    Start_EX = 1'b1; Signed_EX = 1'b0; MTHI_EX = 1'b1;
    Read_Data_1_EX = 32'h0001F00D; Read_Data_2_EX = 32'h00C0FFEE;
    @(negedge Clk);
    Start_EX = 1'b0; MTHI_EX = 1'b0;
    n_checks++;
    if (HI_EX !== 32'h0001F00D || Busy_EX !== 1'b1) begin
      n_fail++; $display("FAIL move_with_start: hi=%h busy=%b, want 0001f00d 1", HI_EX, Busy_EX);
    end
    repeat (4) @(negedge Clk);
    MTLO_EX = 1'b1; MTHI_EX = 1'b1; Read_Data_1_EX = 32'hDEADBEEF;
    @(negedge Clk);
    MTLO_EX = 1'b0; MTHI_EX = 1'b0;
    n_checks++;
    if (LO_EX === 32'hDEADBEEF || HI_EX === 32'hDEADBEEF) begin
      n_fail++; $display("FAIL move_in_run: got %h_%h, move must be dropped", HI_EX, LO_EX);
    end
    cyc = 0;
    while (Done_EX !== 1'b1 && cyc < 60) begin
      cyc++;
      @(negedge Clk);
    end
    n_checks++;
    if (Done_EX !== 1'b1 || {HI_EX, LO_EX} !== exp) begin
      n_fail++; $display("FAIL move_run_result: done=%b got %h_%h, want %h", Done_EX,
                         HI_EX, LO_EX, exp);
    end
  endtask

  task automatic test_start_held;
    logic [63:0] exp;
    int          dones;
    exp = ref_product(32'h00001234, 32'hFFFFFF00, 1'b1);
    dones = 0;
    @(negedge Clk);
    Start_EX = 1'b1; Signed_EX = 1'b1;
    Read_Data_1_EX = 32'h00001234; Read_Data_2_EX = 32'hFFFFFF00;
    for (int i = 0; i < 45; i++) begin
      @(negedge Clk);
      if (i == 25) Start_EX = 1'b0;
      Read_Data_1_EX = $urandom; Read_Data_2_EX = $urandom; Signed_EX = 1'($urandom);
      if (Done_EX === 1'b1) begin
        dones++;
        n_checks++;
        if ({HI_EX, LO_EX} !== exp) begin
          n_fail++; $display("FAIL start_held_result: got %h_%h, want %h", HI_EX, LO_EX, exp);
        end
      end
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++; $display("FAIL start_held_dones: got %0d pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones;
    @(negedge Clk);
    MTHI_EX = 1'b1; Read_Data_1_EX = 32'h0000ABCD;
    @(negedge Clk);
    MTHI_EX = 1'b0;
    Start_EX = 1'b1; Signed_EX = 1'b0; Read_Data_1_EX = 32'h777; Read_Data_2_EX = 32'h999;
    @(negedge Clk);
    Start_EX = 1'b0;
    repeat (10) @(negedge Clk);
    n_checks++;
    if (HI_EX !== 32'h0000ABCD || Busy_EX !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort: hi=%h busy=%b, want 0000abcd 1", HI_EX, Busy_EX);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n_checks++;
    if (HI_EX !== 32'h0 || LO_EX !== 32'h0 || Busy_EX !== 1'b0 || Done_EX !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0",
                         HI_EX, LO_EX, Busy_EX, Done_EX);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done_EX === 1'b1 || Busy_EX === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL abort_no_done: %0d busy/done cycles after abort, want 0", dones);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i == 0) a = 32'h0;
      if (i == 1) b = 32'h1;
      test_mult(a, b, s);
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_moves_idle();
    test_moves_busy();
    test_start_held();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
